resnet_conv: RTL and testbench

Single-channel 3x3 convolution + ReLU layer engine, the compute tile of the ResNet accelerator pipeline. After a flush it pulls 9 kernel weights, then streams an IMG_H x IMG_W input image through a line buffer and emits one valid-only (no padding) output pixel per cycle once each window is complete. All I/O is pull/push by the block itself: it raises read enables and the environment supplies data; it raises write-valid when a result is emitted.

---
 rtl/resnet_pkg.sv | 20 ++
 rtl/resnet_linebuf.sv | 75 +++++++
 rtl/resnet_conv.sv | 141 ++++++++++++++
 tb/tb_resnet_conv.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/resnet_pkg.sv
// Shared definitions for the resnet_conv compute tile.
//   data_t     : signed 16-bit sample/weight/result word
//   *_DEF      : default image geometry and kernel size
//   S_*        : controller state encodings (IDLE -> LOAD_K -> STREAM -> DONE)
package resnet_pkg;

  localparam int DATA_W    = 16;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;
  localparam int KS_DEF    = 3;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_LOAD_K = 2'd1;
  localparam state_t S_STREAM = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/resnet_linebuf.sv
// Two row buffers plus a 3x3 sliding window for raster-order pixel streams.
// Ports:
//   clk       in   clock
//   clear     in   zero both row buffers and the window (frame restart)
//   shift     in   accept pix at column col and advance the window
//   col       in   column of the incoming pixel
//   pix       in   incoming pixel
//   win_next  out  window as it will be after this shift, row-major,
//                  entry t = i*KS+j at bits [t*16 +: 16]; row 2 is newest
module resnet_linebuf
  import resnet_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int KS    = KS_DEF,
  parameter int COL_W = $clog2(IMG_W_DEF)
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     shift,
  input  logic [COL_W-1:0]         col,
  input  logic [DATA_W-1:0]        pix,
  output logic [KS*KS*DATA_W-1:0]  win_next
);

  // lb_p0 holds the previous row, lb_p1 the row before that
  data_t lb_p0 [IMG_W];
  data_t lb_p1 [IMG_W];
  data_t win   [KS][KS];
  data_t nxt   [KS][KS];

  // The window moves one column left; the new right column is the
  // vertical slice {row-2, row-1, row} at the incoming column.
  always_comb begin
    for (int i = 0; i < KS; i++) begin
      for (int j = 0; j < KS - 1; j++) begin
        nxt[i][j] = win[i][j+1];
      end
    end
    nxt[0][KS-1] = lb_p1[col];
    nxt[1][KS-1] = lb_p0[col];
    nxt[2][KS-1] = data_t'(pix);
  end

  always_comb begin
    win_next = '0;
    for (int i = 0; i < KS; i++) begin
      for (int j = 0; j < KS; j++) begin
        win_next[(i*KS+j)*DATA_W +: DATA_W] = nxt[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < IMG_W; k++) begin
        lb_p0[k] <= '0;
        lb_p1[k] <= '0;
      end
      for (int i = 0; i < KS; i++) begin
        for (int j = 0; j < KS; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (shift) begin
      lb_p1[col] <= lb_p0[col];
      lb_p0[col] <= data_t'(pix);
      for (int i = 0; i < KS; i++) begin
        for (int j = 0; j < KS; j++) begin
          win[i][j] <= nxt[i][j];
        end
      end
    end
  end

endmodule

// File: rtl/resnet_conv.sv
// Single-channel 3x3 convolution + ReLU tile (valid-only, no padding).
// After flush it pulls 9 kernel words, then streams IMG_H x IMG_W pixels
// and pushes one result per completed window.
// Ports:
//   clk, rst_n (synchronous, active-high), flush (frame restart pulse)
//   hw_kernel_..._read_en / _read : kernel word request / data
//   hw_input_..._read_en  / _read : input pixel request / data
//   hw_output_..._write_valid / _write : result valid / data (0 when idle)
module resnet_conv
  import resnet_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int KS    = KS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  output logic        hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en,
  input  logic [15:0] hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read,
  output logic        hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  input  logic [15:0] hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read,
  output logic        hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
  output logic [15:0] hw_output_stencil_op_hcompute_hw_output_stencil_write
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NK    = KS * KS;

  localparam logic [3:0]       K_LAST   = 4'(NK - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(KS - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KS - 1);

  state_t           state;
  logic [3:0]       kcnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             kren;
  logic             iren;

  data_t                    kern [NK];
  logic [NK*DATA_W-1:0]     kern_flat;
  logic [NK*DATA_W-1:0]     win_next;
  data_t                    out_p0;
  logic                     vld_p0;

  // Products and the running sum both wrap modulo 2^16.
  function automatic data_t conv_sum(input logic [NK*DATA_W-1:0] w,
                                     input logic [NK*DATA_W-1:0] k);
    logic signed [2*DATA_W-1:0] prod;
    data_t                      acc;
    acc = '0;
    for (int t = 0; t < NK; t++) begin
      prod = data_t'(w[t*DATA_W +: DATA_W]) * data_t'(k[t*DATA_W +: DATA_W]);
      acc  = acc + data_t'(prod[DATA_W-1:0]);
    end
    return acc;
  endfunction

  function automatic data_t relu(input data_t x);
    return x[DATA_W-1] ? data_t'(0) : x;
  endfunction

  assign kren = (state == S_LOAD_K);
  assign iren = (state == S_STREAM);

  assign hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en = kren;
  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en   = iren;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state  <= S_IDLE;
      kcnt   <= '0;
      col    <= '0;
      row    <= '0;
      vld_p0 <= 1'b0;
    end else if (flush) begin
      state  <= S_LOAD_K;
      kcnt   <= '0;
      col    <= '0;
      row    <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        S_LOAD_K: begin
          kcnt <= kcnt + 4'd1;
          if (kcnt == K_LAST) state <= S_STREAM;
        end
        S_STREAM: begin
          // A window completes once at least KS-1 rows and columns precede it.
          vld_p0 <= (row >= ROW_MIN) && (col >= COL_MIN);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
            if (row == ROW_LAST) state <= S_DONE;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (kren) kern[kcnt] <= data_t'(hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read);
  end

  always_comb begin
    kern_flat = '0;
    for (int t = 0; t < NK; t++) begin
      kern_flat[t*DATA_W +: DATA_W] = kern[t];
    end
  end

  resnet_linebuf #(
    .IMG_W (IMG_W),
    .KS    (KS),
    .COL_W (COL_W)
  ) u_linebuf (
    .clk      (clk),
    .clear    (flush),
    .shift    (iren),
    .col      (col),
    .pix      (hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read),
    .win_next (win_next)
  );

  // ---- stage p0: MAC + ReLU on the window that includes the new pixel ----
  always_ff @(posedge clk) begin
    if (iren) out_p0 <= relu(conv_sum(win_next, kern_flat));
  end

  assign hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = vld_p0;
  assign hw_output_stencil_op_hcompute_hw_output_stencil_write       = vld_p0 ? out_p0 : 16'd0;

endmodule

// File: tb/tb_resnet_conv.sv
// Scoreboard bench for resnet_conv: expected results are queued when a frame
// is launched; a monitor pops and compares each emitted pixel, and checks
// read-enable timing every cycle against the frame cycle counter.
module tb_resnet_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        kren;
  logic [15:0] kdata;
  logic        iren;
  logic [15:0] idata;
  logic        wv;
  logic [15:0] wd;

  always #5 clk = ~clk;

  resnet_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read_en (kren),
    .hw_kernel_stencil_op_hcompute_hw_kernel_global_wrapper_stencil_read    (kdata),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en   (iren),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read      (idata),
    .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid            (wv),
    .hw_output_stencil_op_hcompute_hw_output_stencil_write                  (wd)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 1000;
  bit          active     = 1'b0;
  int          kidx       = 0;
  int          iidx       = 0;
  logic [15:0] kmem [9];
  logic [15:0] imem [64];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s (frame cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Frame cycle tracker: cycle 0 is the cycle after flush is sampled.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        active = 1'b0;
        cyc    = 1000;
      end else if (flush) begin
        active = 1'b1;
        cyc    = 0;
        kidx   = 0;
        iidx   = 0;
      end else begin
        cyc++;
      end
    end
  end

  // Environment: supplies the next word of each stream while its read_en is high.
  initial begin
    kdata = '0;
    idata = '0;
    forever begin
      @(negedge clk);
      if (kren && kidx < 9) begin
        kdata = kmem[kidx];
        kidx++;
      end
      if (iren && iidx < 64) begin
        idata = imem[iidx];
        iidx++;
      end
    end
  end

  // Monitor: enable timing every cycle, results popped from the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("kernel_read_en", int'(kren), int'(active && cyc <= 8));
      chk("input_read_en", int'(iren), int'(active && cyc >= 9 && cyc <= 72));
      if (wv) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("output_cycle", cyc, e.cyc);
          chk("output_data", int'(wd), int'(e.data));
        end
      end else begin
        chk("idle_data_zero", int'(wd), 0);
      end
    end
  end

  // mode 0: kernel 1..9 over input 1..64 -> 45*(8r+c)+600; other modes expect 0.
  task automatic push_frame(input int mode, input int last_cyc);
    exp_t e;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        e.cyc  = 10 + (r + 2) * 8 + (c + 2);
        e.data = (mode == 0) ? 16'(45 * (8 * r + c) + 600) : 16'd0;
        if (e.cyc <= last_cyc) sbq.push_back(e);
      end
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 9; i++) kmem[i] = 16'(i + 1);
    for (int i = 0; i < 64; i++) imem[i] = 16'(i + 1);
  endtask

  task automatic drain_check(input string name);
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    load_ramp();
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(wv), 0);
    chk("reset_data", int'(wd), 0);
    chk("reset_kernel_en", int'(kren), 0);
    chk("reset_input_en", int'(iren), 0);

    // flush while reset is held must be ignored
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("reset_over_flush", int'(kren), 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Ramp kernel and ramp image
    push_frame(0, 1000);
    do_flush();
    repeat (85) @(negedge clk);
    drain_check("ramp_all_outputs");

    // All -1 kernel: every sum negative, clamped to 0
    for (int i = 0; i < 9; i++) kmem[i] = 16'hFFFF;
    push_frame(1, 1000);
    do_flush();
    repeat (85) @(negedge clk);
    drain_check("relu_all_outputs");

    // Centre 0x4000 times 4 wraps to 0
    for (int i = 0; i < 9; i++) kmem[i] = 16'h0000;
    kmem[4] = 16'h4000;
    for (int i = 0; i < 64; i++) imem[i] = 16'd4;
    push_frame(1, 1000);
    do_flush();
    repeat (85) @(negedge clk);
    drain_check("wrap_all_outputs");

    // Flush in cycle 40 restarts; the new frame must match the ramp result
    load_ramp();
    push_frame(0, 40);
    push_frame(0, 1000);
    do_flush();
    repeat (40) @(negedge clk);
    do_flush();
    repeat (85) @(negedge clk);
    drain_check("restart_all_outputs");

    // Reset in cycle 35 kills the frame; nothing afterwards
    push_frame(0, 35);
    do_flush();
    repeat (35) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("midreset_valid", int'(wv), 0);
    chk("midreset_kernel_en", int'(kren), 0);
    chk("midreset_input_en", int'(iren), 0);
    repeat (20) @(negedge clk);
    drain_check("midreset_outputs");
    chk("post_reset_input_en", int'(iren), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
